// File: rtl/cpu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : cpu                                                   |
// | Desc     : Five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS     |
// |            subset core with EX forwarding, load-use stall and    |
// |            ID-resolved beq/j with a one-slot IF/ID flush.        |
// |            Instruction memory, data memory and register file     |
// |            are internal.                                         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+

// ---------------------------------------------------------------------
// Program counter register
// ---------------------------------------------------------------------
module cpu_pc (
   input  wire         clk_i,
   input  wire         rst_i,
   input  wire         i_en,
   input  wire  [31:0] i_pc_next,
   output logic [31:0] pc_o
);
   // PC advances only when enabled; async clear to address 0
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)    pc_o <= '0;
      else if (i_en) pc_o <= i_pc_next;
   end
endmodule

// ---------------------------------------------------------------------
// Instruction memory: 256 words, combinational read
// ---------------------------------------------------------------------
module cpu_imem (
   input  wire         clk_i,
   input  wire         i_we,
   input  wire  [7:0]  i_waddr,
   input  wire  [31:0] i_wdata,
   input  wire  [7:0]  i_word,
   output logic [31:0] o_instr
);
   logic [31:0] memory [0:255];

   // Load port for program images; contents are not touched by reset
   always_ff @(posedge clk_i) begin
      if (i_we) memory[i_waddr] <= i_wdata;
   end

   assign o_instr = memory[i_word];
endmodule

// ---------------------------------------------------------------------
// Data memory: 32 bytes, little-endian word access
// ---------------------------------------------------------------------
module cpu_dmem (
   input  wire         clk_i,
   input  wire         i_we,
   input  wire  [4:0]  i_addr,
   input  wire  [31:0] i_wdata,
   output logic [31:0] o_rdata
);
   logic [7:0] memory [0:31];
   logic [4:0] w_a1;
   logic [4:0] w_a2;
   logic [4:0] w_a3;

   assign w_a1 = i_addr + 5'd1;
   assign w_a2 = i_addr + 5'd2;
   assign w_a3 = i_addr + 5'd3;

   // Store writes all four bytes, least significant byte at the base address
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         memory[i_addr] <= i_wdata[7:0];
         memory[w_a1]   <= i_wdata[15:8];
         memory[w_a2]   <= i_wdata[23:16];
         memory[w_a3]   <= i_wdata[31:24];
      end
   end

   assign o_rdata = {memory[w_a3], memory[w_a2], memory[w_a1], memory[i_addr]};
endmodule

// ---------------------------------------------------------------------
// Register file: 32 x 32, two read ports with write-through bypass
// ---------------------------------------------------------------------
module cpu_regfile (
   input  wire         clk_i,
   input  wire         i_we,
   input  wire  [4:0]  i_waddr,
   input  wire  [31:0] i_wdata,
   input  wire  [4:0]  i_raddr1,
   input  wire  [4:0]  i_raddr2,
   output logic [31:0] o_rdata1,
   output logic [31:0] o_rdata2
);
   logic [31:0] register [0:31];

   // Writeback port; r0 is hard-wired to zero so writes to it are dropped
   always_ff @(posedge clk_i) begin
      if (i_we && (i_waddr != 5'd0)) register[i_waddr] <= i_wdata;
   end

   // Read ports see a same-cycle writeback so ID never reads a stale value
   always_comb begin
      if (i_raddr1 == 5'd0)                      o_rdata1 = '0;
      else if (i_we && (i_waddr == i_raddr1))    o_rdata1 = i_wdata;
      else                                       o_rdata1 = register[i_raddr1];
      if (i_raddr2 == 5'd0)                      o_rdata2 = '0;
      else if (i_we && (i_waddr == i_raddr2))    o_rdata2 = i_wdata;
      else                                       o_rdata2 = register[i_raddr2];
   end
endmodule

// ---------------------------------------------------------------------
// Load-use hazard detection
// ---------------------------------------------------------------------
module cpu_hazard (
   input  wire        i_idex_memread,
   input  wire  [4:0] i_idex_rt,
   input  wire  [4:0] i_ifid_rs,
   input  wire  [4:0] i_ifid_rt,
   output logic       pcwrite,
   output logic       IFIDwrite,
   output logic       bubble_ctrl
);
   // A load in EX whose target feeds the instruction in ID costs one bubble
   always_comb begin
      bubble_ctrl = i_idex_memread &&
                    ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
      pcwrite     = !bubble_ctrl;
      IFIDwrite   = !bubble_ctrl;
   end
endmodule

// ---------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------
module cpu (
   input wire clk_i,
   input wire rst_i,
   input wire start_i
);
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [5:0] c_fn_add   = 6'b100000;
   localparam logic [5:0] c_fn_sub   = 6'b100010;
   localparam logic [5:0] c_fn_and   = 6'b100100;
   localparam logic [5:0] c_fn_or    = 6'b100101;
   localparam logic [5:0] c_fn_mul   = 6'b011000;

   localparam logic [2:0] c_alu_add  = 3'd0;
   localparam logic [2:0] c_alu_sub  = 3'd1;
   localparam logic [2:0] c_alu_and  = 3'd2;
   localparam logic [2:0] c_alu_or   = 3'd3;
   localparam logic [2:0] c_alu_mul  = 3'd4;

   // ---------------- IF ----------------
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic [31:0] w_pc_next;
   logic [31:0] w_instr;
   logic        w_pcwrite;
   logic        w_ifidwrite;
   logic        w_bubble;

   // ---------------- IF/ID ----------------
   logic [31:0] r_ifid_pc4;
   logic [31:0] r_ifid_instr;

   // ---------------- ID ----------------
   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [31:0] w_simm;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;
   logic        w_regwrite;
   logic        w_memread;
   logic        w_memwrite;
   logic        w_memtoreg;
   logic        w_alusrc;
   logic [2:0]  w_aluop;
   logic [4:0]  w_dst;
   logic        w_branch;
   logic        w_jump;
   logic        w_taken;
   logic        w_redirect;
   logic [31:0] w_btarget;
   logic [31:0] w_jtarget;

   // ---------------- ID/EX ----------------
   logic        r_idex_regwrite;
   logic        r_idex_memread;
   logic        r_idex_memwrite;
   logic        r_idex_memtoreg;
   logic        r_idex_alusrc;
   logic [2:0]  r_idex_aluop;
   logic [31:0] r_idex_rd1;
   logic [31:0] r_idex_rd2;
   logic [31:0] r_idex_imm;
   logic [4:0]  r_idex_rs;
   logic [4:0]  r_idex_rt;
   logic [4:0]  r_idex_dst;

   // ---------------- EX ----------------
   logic [31:0] w_fwd_a;
   logic [31:0] w_fwd_b;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_y;

   // ---------------- EX/MEM ----------------
   logic        r_exmem_regwrite;
   logic        r_exmem_memwrite;
   logic        r_exmem_memtoreg;
   logic [31:0] r_exmem_alu;
   logic [31:0] r_exmem_sdata;
   logic [4:0]  r_exmem_dst;

   // ---------------- MEM ----------------
   logic [31:0] w_dmem_rdata;

   // ---------------- MEM/WB ----------------
   logic        r_memwb_regwrite;
   logic        r_memwb_memtoreg;
   logic [31:0] r_memwb_rdata;
   logic [31:0] r_memwb_alu;
   logic [4:0]  r_memwb_dst;

   // ---------------- WB ----------------
   logic [31:0] w_wb_data;

   // ================= IF =================
   assign w_pc4     = w_pc + 32'd4;
   assign w_pc_next = w_jump  ? w_jtarget :
                      w_taken ? w_btarget : w_pc4;

   cpu_pc PC (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_en      (start_i && w_pcwrite),
      .i_pc_next (w_pc_next),
      .pc_o      (w_pc)
   );

   cpu_imem Instruction_Memory (
      .clk_i   (clk_i),
      .i_we    (1'b0),
      .i_waddr (8'd0),
      .i_wdata (32'd0),
      .i_word  (w_pc[9:2]),
      .o_instr (w_instr)
   );

   // IF/ID: flushed to NOP on a redirect, held during a load-use stall
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ifid_pc4   <= '0;
         r_ifid_instr <= '0;
      end else if (w_redirect) begin
         r_ifid_pc4   <= '0;
         r_ifid_instr <= '0;
      end else if (w_ifidwrite) begin
         r_ifid_pc4   <= w_pc4;
         r_ifid_instr <= w_instr;
      end
   end

   // ================= ID =================
   assign w_op    = r_ifid_instr[31:26];
   assign w_rs    = r_ifid_instr[25:21];
   assign w_rt    = r_ifid_instr[20:16];
   assign w_rd    = r_ifid_instr[15:11];
   assign w_funct = r_ifid_instr[5:0];
   assign w_simm  = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

   cpu_regfile Registers (
      .clk_i    (clk_i),
      .i_we     (r_memwb_regwrite),
      .i_waddr  (r_memwb_dst),
      .i_wdata  (w_wb_data),
      .i_raddr1 (w_rs),
      .i_raddr2 (w_rt),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2)
   );

   cpu_hazard HazardDetection (
      .i_idex_memread (r_idex_memread),
      .i_idex_rt      (r_idex_rt),
      .i_ifid_rs      (w_rs),
      .i_ifid_rt      (w_rt),
      .pcwrite        (w_pcwrite),
      .IFIDwrite      (w_ifidwrite),
      .bubble_ctrl    (w_bubble)
   );

   // Main decoder; anything unrecognised leaves every control bit low (NOP)
   always_comb begin
      w_regwrite = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_alusrc   = 1'b0;
      w_aluop    = c_alu_add;
      w_dst      = w_rt;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      case (w_op)
         c_op_rtype: begin
            w_dst = w_rd;
            case (w_funct)
               c_fn_add: begin w_regwrite = 1'b1; w_aluop = c_alu_add; end
               c_fn_sub: begin w_regwrite = 1'b1; w_aluop = c_alu_sub; end
               c_fn_and: begin w_regwrite = 1'b1; w_aluop = c_alu_and; end
               c_fn_or:  begin w_regwrite = 1'b1; w_aluop = c_alu_or;  end
               c_fn_mul: begin w_regwrite = 1'b1; w_aluop = c_alu_mul; end
               default:  ;
            endcase
         end
         c_op_addi: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
         end
         c_op_lw: begin
            w_regwrite = 1'b1;
            w_memread  = 1'b1;
            w_memtoreg = 1'b1;
            w_alusrc   = 1'b1;
         end
         c_op_sw: begin
            w_memwrite = 1'b1;
            w_alusrc   = 1'b1;
         end
         c_op_beq: w_branch = 1'b1;
         c_op_j:   w_jump   = 1'b1;
         default:  ;
      endcase
   end

   // beq compares raw register-file values; the scheduler guarantees they are final
   assign w_taken    = w_branch && (w_rd1 == w_rd2);
   assign w_btarget  = r_ifid_pc4 + (w_simm << 2);
   assign w_jtarget  = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
   // A stall wins over a redirect; the branch re-evaluates once the bubble passes
   assign w_redirect = (w_jump || w_taken) && !w_bubble;

   // ID/EX: a stall inserts an all-zero bubble
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_idex_regwrite <= 1'b0;
         r_idex_memread  <= 1'b0;
         r_idex_memwrite <= 1'b0;
         r_idex_memtoreg <= 1'b0;
         r_idex_alusrc   <= 1'b0;
         r_idex_aluop    <= c_alu_add;
         r_idex_rd1      <= '0;
         r_idex_rd2      <= '0;
         r_idex_imm      <= '0;
         r_idex_rs       <= '0;
         r_idex_rt       <= '0;
         r_idex_dst      <= '0;
      end else if (w_bubble) begin
         r_idex_regwrite <= 1'b0;
         r_idex_memread  <= 1'b0;
         r_idex_memwrite <= 1'b0;
         r_idex_memtoreg <= 1'b0;
         r_idex_alusrc   <= 1'b0;
         r_idex_aluop    <= c_alu_add;
         r_idex_rd1      <= '0;
         r_idex_rd2      <= '0;
         r_idex_imm      <= '0;
         r_idex_rs       <= '0;
         r_idex_rt       <= '0;
         r_idex_dst      <= '0;
      end else begin
         r_idex_regwrite <= w_regwrite;
         r_idex_memread  <= w_memread;
         r_idex_memwrite <= w_memwrite;
         r_idex_memtoreg <= w_memtoreg;
         r_idex_alusrc   <= w_alusrc;
         r_idex_aluop    <= w_aluop;
         r_idex_rd1      <= w_rd1;
         r_idex_rd2      <= w_rd2;
         r_idex_imm      <= w_simm;
         r_idex_rs       <= w_rs;
         r_idex_rt       <= w_rt;
         r_idex_dst      <= w_dst;
      end
   end

   // ================= EX =================
   // Operand forwarding: the younger EX/MEM result beats MEM/WB
   always_comb begin
      w_fwd_a = r_idex_rd1;
      if (r_exmem_regwrite && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rs))
         w_fwd_a = r_exmem_alu;
      else if (r_memwb_regwrite && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rs))
         w_fwd_a = w_wb_data;

      w_fwd_b = r_idex_rd2;
      if (r_exmem_regwrite && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rt))
         w_fwd_b = r_exmem_alu;
      else if (r_memwb_regwrite && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rt))
         w_fwd_b = w_wb_data;
   end

   assign w_alu_b = r_idex_alusrc ? r_idex_imm : w_fwd_b;

   // ALU; mul keeps only the low 32 bits of the product
   always_comb begin
      w_alu_y = w_fwd_a + w_alu_b;
      case (r_idex_aluop)
         c_alu_sub: w_alu_y = w_fwd_a - w_alu_b;
         c_alu_and: w_alu_y = w_fwd_a & w_alu_b;
         c_alu_or:  w_alu_y = w_fwd_a | w_alu_b;
         c_alu_mul: w_alu_y = w_fwd_a * w_alu_b;
         default:   ;
      endcase
   end

   // EX/MEM: store data carries the forwarded rt value
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_exmem_regwrite <= 1'b0;
         r_exmem_memwrite <= 1'b0;
         r_exmem_memtoreg <= 1'b0;
         r_exmem_alu      <= '0;
         r_exmem_sdata    <= '0;
         r_exmem_dst      <= '0;
      end else begin
         r_exmem_regwrite <= r_idex_regwrite;
         r_exmem_memwrite <= r_idex_memwrite;
         r_exmem_memtoreg <= r_idex_memtoreg;
         r_exmem_alu      <= w_alu_y;
         r_exmem_sdata    <= w_fwd_b;
         r_exmem_dst      <= r_idex_dst;
      end
   end

   // ================= MEM =================
   cpu_dmem Data_Memory (
      .clk_i   (clk_i),
      .i_we    (r_exmem_memwrite),
      .i_addr  (r_exmem_alu[4:0]),
      .i_wdata (r_exmem_sdata),
      .o_rdata (w_dmem_rdata)
   );

   // MEM/WB pipeline register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_memwb_regwrite <= 1'b0;
         r_memwb_memtoreg <= 1'b0;
         r_memwb_rdata    <= '0;
         r_memwb_alu      <= '0;
         r_memwb_dst      <= '0;
      end else begin
         r_memwb_regwrite <= r_exmem_regwrite;
         r_memwb_memtoreg <= r_exmem_memtoreg;
         r_memwb_rdata    <= w_dmem_rdata;
         r_memwb_alu      <= r_exmem_alu;
         r_memwb_dst      <= r_exmem_dst;
      end
   end

   // ================= WB =================
   assign w_wb_data = r_memwb_memtoreg ? r_memwb_rdata : r_memwb_alu;

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_cpu                                                 |
// | Desc     : Self-checking bench for the pipelined cpu. Programs    |
// |            are preloaded through hierarchical names; expected     |
// |            register values and PC traces are queued up front and |
// |            popped against the running design.                   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_cpu;
   logic clk;
   logic rst_n;
   logic start;

   int n_checks;
   int n_errors;

   typedef struct {
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pc_q[$];

   cpu dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .start_i (start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'b000010, t};
   endfunction

   // Hold reset, clear instruction memory and general registers
   task automatic begin_prog();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
      for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'h0;
   endtask

   task automatic release_run();
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] held;
      begin_prog();
      dut.Registers.register[8] = 32'hA5A5_A5A5;
      for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = 8'(i);
      @(negedge clk);
      n_checks++;
      if (dut.PC.pc_o !== 32'h0) begin
         n_errors++; $display("FAIL reset_pc: got %h expected 0", dut.PC.pc_o);
      end
      n_checks++;
      if (dut.HazardDetection.bubble_ctrl !== 1'b0 || dut.HazardDetection.pcwrite !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_hazard: bubble %b pcwrite %b expected 0/1",
                  dut.HazardDetection.bubble_ctrl, dut.HazardDetection.pcwrite);
      end
      for (int i = 1; i <= 8; i++) pc_q.push_back(32'(4 * i));
      release_run();
      repeat (8) begin
         @(negedge clk);
         held = pc_q.pop_front();
         n_checks++;
         if (dut.PC.pc_o !== held) begin
            n_errors++; $display("FAIL nop_pc: got %h expected %h", dut.PC.pc_o, held);
         end
         n_checks++;
         if (dut.HazardDetection.bubble_ctrl !== 1'b0) begin
            n_errors++; $display("FAIL nop_bubble: got 1 expected 0");
         end
      end
      // start low freezes the PC
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (dut.PC.pc_o !== 32'd32) begin
            n_errors++; $display("FAIL start_hold_pc: got %h expected 20", dut.PC.pc_o);
         end
      end
      start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut.PC.pc_o !== 32'd36) begin
         n_errors++; $display("FAIL start_resume_pc: got %h expected 24", dut.PC.pc_o);
      end
      n_checks++;
      if (dut.Registers.register[8] !== 32'hA5A5_A5A5) begin
         n_errors++; $display("FAIL nop_reg: got %h expected a5a5a5a5", dut.Registers.register[8]);
      end
      n_checks++;
      if (dut.Data_Memory.memory[5] !== 8'd5) begin
         n_errors++; $display("FAIL nop_dmem: got %h expected 05", dut.Data_Memory.memory[5]);
      end
   endtask

   task automatic test_forwarding();
      exp_t e;
      begin_prog();
      dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
      dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
      dut.Instruction_Memory.memory[2] = enc_r(5'd9, 5'd8, 5'd10, 6'h20);
      exp_q.push_back('{8, 32'd5});
      exp_q.push_back('{9, 32'd8});
      exp_q.push_back('{10, 32'd13});
      release_run();
      repeat (10) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (dut.Registers.register[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL fwd_r%0d: got %h expected %h", e.idx, dut.Registers.register[e.idx], e.val);
         end
      end
   endtask

   task automatic test_load_use();
      exp_t        e;
      int          n_stall;
      logic [31:0] stall_pc;
      logic        prev_stall;
      begin_prog();
      dut.Data_Memory.memory[0] = 8'd5;
      dut.Data_Memory.memory[1] = 8'd0;
      dut.Data_Memory.memory[2] = 8'd0;
      dut.Data_Memory.memory[3] = 8'd0;
      dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
      dut.Instruction_Memory.memory[1] = enc_r(5'd8, 5'd8, 5'd9, 6'h20);
      exp_q.push_back('{8, 32'd5});
      exp_q.push_back('{9, 32'd10});
      n_stall    = 0;
      stall_pc   = 32'hFFFF_FFFF;
      prev_stall = 1'b0;
      release_run();
      repeat (10) begin
         @(negedge clk);
         if (prev_stall) begin
            n_checks++;
            if (dut.PC.pc_o !== stall_pc) begin
               n_errors++; $display("FAIL stall_pc_hold: got %h expected %h", dut.PC.pc_o, stall_pc);
            end
         end
         prev_stall = 1'b0;
         if (dut.HazardDetection.bubble_ctrl === 1'b1) begin
            n_stall++;
            prev_stall = 1'b1;
            stall_pc   = dut.PC.pc_o;
            n_checks++;
            if (dut.HazardDetection.pcwrite !== 1'b0 || dut.HazardDetection.IFIDwrite !== 1'b0) begin
               n_errors++;
               $display("FAIL stall_ctrl: pcwrite %b IFIDwrite %b expected 0/0",
                        dut.HazardDetection.pcwrite, dut.HazardDetection.IFIDwrite);
            end
         end
      end
      n_checks++;
      if (n_stall != 1) begin
         n_errors++; $display("FAIL stall_count: got %0d expected 1", n_stall);
      end
      n_checks++;
      if (stall_pc !== 32'd8) begin
         n_errors++; $display("FAIL stall_at_pc: got %h expected 8", stall_pc);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (dut.Registers.register[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL loaduse_r%0d: got %h expected %h", e.idx, dut.Registers.register[e.idx], e.val);
         end
      end
   endtask

   task automatic test_alu_store();
      exp_t        e;
      logic [31:0] word4;
      begin_prog();
      for (int i = 4; i < 8; i++) dut.Data_Memory.memory[i] = 8'hFF;
      dut.Registers.register[14] = 32'h0000_1234;
      dut.Instruction_Memory.memory[0]  = enc_i(6'h08, 5'd0, 5'd8, 16'd6);
      dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 5'd0, 5'd9, 16'd3);
      dut.Instruction_Memory.memory[2]  = enc_r(5'd8, 5'd9, 5'd10, 6'h22);
      dut.Instruction_Memory.memory[3]  = enc_r(5'd8, 5'd9, 5'd11, 6'h24);
      dut.Instruction_Memory.memory[4]  = enc_r(5'd8, 5'd9, 5'd13, 6'h25);
      dut.Instruction_Memory.memory[5]  = enc_r(5'd8, 5'd9, 5'd12, 6'h18);
      dut.Instruction_Memory.memory[6]  = enc_i(6'h2B, 5'd0, 5'd12, 16'd4);
      dut.Instruction_Memory.memory[7]  = enc_r(5'd8, 5'd9, 5'd14, 6'h2A);
      dut.Instruction_Memory.memory[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
      dut.Instruction_Memory.memory[9]  = enc_r(5'd0, 5'd9, 5'd15, 6'h20);
      dut.Instruction_Memory.memory[10] = 32'hFC00_0000;
      exp_q.push_back('{10, 32'd3});
      exp_q.push_back('{11, 32'd2});
      exp_q.push_back('{13, 32'd7});
      exp_q.push_back('{12, 32'd18});
      exp_q.push_back('{14, 32'h0000_1234});
      exp_q.push_back('{0, 32'd0});
      exp_q.push_back('{15, 32'd3});
      release_run();
      repeat (20) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (dut.Registers.register[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL alu_r%0d: got %h expected %h", e.idx, dut.Registers.register[e.idx], e.val);
         end
      end
      word4 = {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
               dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]};
      n_checks++;
      if (word4 !== 32'd18) begin
         n_errors++; $display("FAIL sw_word4: got %h expected 00000012", word4);
      end
   endtask

   task automatic test_branch_jump();
      exp_t        e;
      logic [31:0] want;
      begin_prog();
      dut.Registers.register[9]  = 32'hDEAD;
      dut.Registers.register[10] = 32'hDEAD;
      dut.Registers.register[12] = 32'hDEAD;
      dut.Instruction_Memory.memory[0]  = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
      dut.Instruction_Memory.memory[1]  = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
      dut.Instruction_Memory.memory[2]  = enc_i(6'h08, 5'd0, 5'd9, 16'd99);
      dut.Instruction_Memory.memory[3]  = enc_i(6'h08, 5'd0, 5'd10, 16'd77);
      dut.Instruction_Memory.memory[4]  = enc_i(6'h08, 5'd0, 5'd11, 16'd5);
      dut.Instruction_Memory.memory[5]  = enc_j(26'h10);
      dut.Instruction_Memory.memory[6]  = enc_i(6'h08, 5'd0, 5'd12, 16'd33);
      dut.Instruction_Memory.memory[16] = enc_i(6'h08, 5'd0, 5'd13, 16'd44);
      pc_q = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd24, 32'h40, 32'h44, 32'h48};
      exp_q.push_back('{8, 32'd1});
      exp_q.push_back('{9, 32'hDEAD});
      exp_q.push_back('{10, 32'hDEAD});
      exp_q.push_back('{11, 32'd5});
      exp_q.push_back('{12, 32'hDEAD});
      exp_q.push_back('{13, 32'd44});
      release_run();
      while (pc_q.size() > 0) begin
         @(negedge clk);
         want = pc_q.pop_front();
         n_checks++;
         if (dut.PC.pc_o !== want) begin
            n_errors++; $display("FAIL br_pc_trace: got %h expected %h", dut.PC.pc_o, want);
         end
      end
      repeat (6) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (dut.Registers.register[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL br_r%0d: got %h expected %h", e.idx, dut.Registers.register[e.idx], e.val);
         end
      end
   endtask

   task automatic test_reset_midrun();
      exp_t e;
      begin_prog();
      dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd20, 16'd11);
      dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd21, 5'd21, 16'd1);
      release_run();
      repeat (10) @(negedge clk);
      n_checks++;
      if (dut.Registers.register[21] !== 32'd1) begin
         n_errors++; $display("FAIL mid_first_r21: got %h expected 1", dut.Registers.register[21]);
      end
      // Assert reset between edges; the PC must clear without waiting for a clock
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut.PC.pc_o !== 32'h0) begin
         n_errors++; $display("FAIL mid_async_pc: got %h expected 0", dut.PC.pc_o);
      end
      n_checks++;
      if (dut.Registers.register[20] !== 32'd11) begin
         n_errors++; $display("FAIL mid_reg_kept: got %h expected b", dut.Registers.register[20]);
      end
      dut.Registers.register[20] = 32'h0;
      exp_q.push_back('{20, 32'd11});
      exp_q.push_back('{21, 32'd2});
      release_run();
      @(negedge clk);
      n_checks++;
      if (dut.PC.pc_o !== 32'd4) begin
         n_errors++; $display("FAIL mid_restart_pc: got %h expected 4", dut.PC.pc_o);
      end
      repeat (8) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (dut.Registers.register[e.idx] !== e.val) begin
            n_errors++;
            $display("FAIL mid_r%0d: got %h expected %h", e.idx, dut.Registers.register[e.idx], e.val);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_alu_store();
      test_branch_jump();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
